// File: rtl/csr_pkg.sv
// Shared constants for the machine/user CSR block: addresses, mstatus and
// interrupt bit positions, privilege mode and mtvec mode encodings.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mie / mip bit positions
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    // Privilege modes; only M and U exist on this core
    typedef enum logic [1:0] {
        MODE_U = 2'b00,
        MODE_M = 2'b11
    } mode_e;

    // mtvec mode field encodings
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // WARL legalisation of a written MPP field: anything but M collapses to U
    function automatic mode_e legal_mpp(input logic [1:0] v);
        return (v == 2'b11) ? MODE_M : MODE_U;
    endfunction

    // WARL legalisation of mtvec mode: only "vectored" survives as a 1
    function automatic logic legal_mtvec_vec(input logic [1:0] v);
        return (v == MTVEC_VECTORED);
    endfunction

endpackage

// File: rtl/csr_if.sv
// Bus between the pipeline (master) and the CSR file (slave).
// There is no back-pressure on this path: csr_we, trap_valid, mret and
// instret are single-cycle strobes that the CSR file always accepts at the
// next rising clk; every slave output is combinational and valid each cycle.
interface csr_if;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_addr_bad;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic [1:0]  current_mode;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_req;

    modport master (
        output csr_raddr, csr_we, csr_waddr, csr_wdata,
               trap_valid, trap_cause, trap_pc, trap_tval,
               mret, instret, irq_ext, irq_timer, irq_sw,
        input  csr_rdata, csr_addr_bad, current_mode,
               trap_vector, mepc_out, irq_req
    );

    modport slave (
        input  csr_raddr, csr_we, csr_waddr, csr_wdata,
               trap_valid, trap_cause, trap_pc, trap_tval,
               mret, instret, irq_ext, irq_timer, irq_sw,
        output csr_rdata, csr_addr_bad, current_mode,
               trap_vector, mepc_out, irq_req
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter split into two 32-bit halves, each writable.
// A write to a half replaces that half's update; a low-half write also
// blocks the carry into the high half for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    // Next value of both halves, including write override and carry
    always_comb begin
        carry = inc_i & ~we_lo_i & (lo_q == 32'hFFFF_FFFF);
        lo_d  = we_lo_i ? wdata_i : (lo_q + {31'd0, inc_i});
        hi_d  = we_hi_i ? wdata_i : (hi_q + {31'd0, carry});
    end

    // Counter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo_o = lo_q;
    assign hi_o = hi_q;

endmodule

// File: rtl/csr_file.sv
// Machine/user CSR storage, trap entry / mret state updates, interrupt
// request generation and the combinational CSR read mux.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input logic   clk,
    input logic   rst,
    csr_if.slave  bus
);

    mode_e       mode_q, mode_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    mode_e       st_mpp_q, st_mpp_d;
    logic [31:0] mie_q, mie_d;
    logic [29:0] mtvec_base_q, mtvec_base_d;
    logic        mtvec_vec_q, mtvec_vec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic        csr_wr_en;
    logic [31:0] mstatus_rd;
    logic [31:0] mip_rd;
    logic [31:0] mtvec_rd;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic [31:0] rdata;
    logic        addr_bad;

    // A CSR write is dropped whenever a trap or mret owns this cycle
    assign csr_wr_en = bus.csr_we & ~bus.trap_valid & ~bus.mret;

    csr_counter64 u_cycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .we_lo_i (csr_wr_en && (bus.csr_waddr == CSR_MCYCLE)),
        .we_hi_i (csr_wr_en && (bus.csr_waddr == CSR_MCYCLEH)),
        .wdata_i (bus.csr_wdata),
        .lo_o    (cyc_lo),
        .hi_o    (cyc_hi)
    );

    csr_counter64 u_instret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bus.instret),
        .we_lo_i (csr_wr_en && (bus.csr_waddr == CSR_MINSTRET)),
        .we_hi_i (csr_wr_en && (bus.csr_waddr == CSR_MINSTRETH)),
        .wdata_i (bus.csr_wdata),
        .lo_o    (ins_lo),
        .hi_o    (ins_hi)
    );

    // Next-state for mode/trap registers: trap > mret > CSR write
    always_comb begin
        mode_d       = mode_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        st_mpp_d     = st_mpp_q;
        mie_d        = mie_q;
        mtvec_base_d = mtvec_base_q;
        mtvec_vec_d  = mtvec_vec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        if (bus.trap_valid) begin
            mepc_d    = bus.trap_pc & ~32'd3;
            mcause_d  = bus.trap_cause;
            mtval_d   = bus.trap_tval;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            st_mpp_d  = mode_q;
            mode_d    = MODE_M;
        end else if (bus.mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            mode_d    = st_mpp_q;
            st_mpp_d  = MODE_U;
        end else if (bus.csr_we) begin
            case (bus.csr_waddr)
                CSR_MSTATUS: begin
                    st_mie_d  = bus.csr_wdata[MSTATUS_MIE];
                    st_mpie_d = bus.csr_wdata[MSTATUS_MPIE];
                    st_mpp_d  = legal_mpp(bus.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                end
                CSR_MIE:      mie_d = bus.csr_wdata & MIE_MASK;
                CSR_MTVEC: begin
                    mtvec_base_d = bus.csr_wdata[31:2];
                    mtvec_vec_d  = legal_mtvec_vec(bus.csr_wdata[1:0]);
                end
                CSR_MSCRATCH: mscratch_d = bus.csr_wdata;
                CSR_MEPC:     mepc_d     = bus.csr_wdata & ~32'd3;
                CSR_MCAUSE:   mcause_d   = bus.csr_wdata;
                CSR_MTVAL:    mtval_d    = bus.csr_wdata;
                default: ;
            endcase
        end
    end

    // Mode, mstatus fields and trap CSR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_M;
            st_mie_q     <= 1'b0;
            st_mpie_q    <= 1'b0;
            st_mpp_q     <= MODE_U;
            mie_q        <= '0;
            mtvec_base_q <= '0;
            mtvec_vec_q  <= 1'b0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else begin
            mode_q       <= mode_d;
            st_mie_q     <= st_mie_d;
            st_mpie_q    <= st_mpie_d;
            st_mpp_q     <= st_mpp_d;
            mie_q        <= mie_d;
            mtvec_base_q <= mtvec_base_d;
            mtvec_vec_q  <= mtvec_vec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
        end
    end

    // Assemble the architectural views of mstatus, mip and mtvec
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]  = st_mie_q;
        mstatus_rd[MSTATUS_MPIE] = st_mpie_q;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = st_mpp_q;
        mip_rd = '0;
        mip_rd[IRQ_MEI] = bus.irq_ext;
        mip_rd[IRQ_MTI] = bus.irq_timer;
        mip_rd[IRQ_MSI] = bus.irq_sw;
        mtvec_rd = {mtvec_base_q, 1'b0, mtvec_vec_q};
    end

    // Combinational read mux; unknown addresses read 0 and flag bad
    always_comb begin
        rdata    = '0;
        addr_bad = 1'b0;
        case (bus.csr_raddr)
            CSR_MSTATUS:   rdata = mstatus_rd;
            CSR_MISA:      rdata = MISA_VAL;
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_rd;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip_rd;
            CSR_MCYCLE,
            CSR_CYCLE:     rdata = cyc_lo;
            CSR_MCYCLEH,
            CSR_CYCLEH:    rdata = cyc_hi;
            CSR_MINSTRET,
            CSR_INSTRET:   rdata = ins_lo;
            CSR_MINSTRETH,
            CSR_INSTRETH:  rdata = ins_hi;
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:    rdata = '0;
            CSR_MHARTID:   rdata = HART_ID;
            default:       addr_bad = 1'b1;
        endcase
    end

    // Trap target, mret target, mode and interrupt request outputs
    always_comb begin
        bus.csr_rdata    = rdata;
        bus.csr_addr_bad = addr_bad;
        bus.current_mode = mode_q;
        bus.mepc_out     = mepc_q;
        bus.trap_vector  = {mtvec_base_q, 2'b00};
        if (mtvec_vec_q && bus.trap_cause[31])
            bus.trap_vector = {mtvec_base_q, 2'b00} + {25'd0, bus.trap_cause[4:0], 2'b00};
        bus.irq_req = ((mode_q == MODE_U) || st_mie_q) && (|(mie_q & mip_rd));
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with hand-computed expected values.
module tb_csr_file;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  csr_if bus ();

  csr_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_raddr = a;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we    = 1'b1;
    bus.csr_waddr = a;
    bus.csr_wdata = d;
    tick();
    bus.csr_we    = 1'b0;
  endtask

  task automatic trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_valid = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
    tick();
    bus.trap_valid = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.csr_raddr  = '0;
    bus.csr_we     = 1'b0;
    bus.csr_waddr  = '0;
    bus.csr_wdata  = '0;
    bus.trap_valid = 1'b0;
    bus.trap_cause = '0;
    bus.trap_pc    = '0;
    bus.trap_tval  = '0;
    bus.mret       = 1'b0;
    bus.instret    = 1'b0;
    bus.irq_ext    = 1'b0;
    bus.irq_timer  = 1'b0;
    bus.irq_sw     = 1'b0;
    repeat (3) @(posedge clk);
    #5 rst = 1'b0;
    tick();

    // reset state and read-back
    check("rst_mode", {30'd0, bus.current_mode}, 32'd3);
    check("rst_irq", {31'd0, bus.irq_req}, 32'd0);
    check("rst_tvec", bus.trap_vector, 32'd0);
    check("rst_mepc_out", bus.mepc_out, 32'd0);
    rd_chk("rst_mstatus", 12'h300, 32'd0);
    rd_chk("misa", 12'h301, 32'h4000_0100);
    rd_chk("rst_mtvec", 12'h305, 32'd0);
    rd_chk("mhartid", 12'hF14, 32'd0);
    rd_chk("mvendorid", 12'hF11, 32'd0);
    check("f11_ok", {31'd0, bus.csr_addr_bad}, 32'd0);
    wr(12'h340, 32'hDEAD_BEEF);
    rd_chk("mscratch", 12'h340, 32'hDEAD_BEEF);

    // counter write vs increment
    wr(12'hB80, 32'd5);
    wr(12'hB00, 32'hFFFF_FFFF);
    rd_chk("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("cyc_hi_nocarry", 12'hB80, 32'd5);
    tick();
    rd_chk("cyc_lo_wrap", 12'hB00, 32'd0);
    rd_chk("cyc_hi_carry", 12'hB80, 32'd6);
    rd_chk("cycle_shadow", 12'hC00, 32'd0);
    rd_chk("cycleh_shadow", 12'hC80, 32'd6);
    tick();
    wr(12'hB80, 32'd7);
    rd_chk("cyc_hi_wr", 12'hB80, 32'd7);
    rd_chk("cyc_lo_runs", 12'hB00, 32'd2);

    // instret counting
    rd_chk("instret0", 12'hB02, 32'd0);
    bus.instret = 1'b1;
    repeat (3) tick();
    bus.instret = 1'b0;
    rd_chk("instret3", 12'hB02, 32'd3);
    bus.instret = 1'b1;
    wr(12'hB02, 32'd10);
    bus.instret = 1'b0;
    rd_chk("instret_wr", 12'hB02, 32'd10);
    rd_chk("instret_sh", 12'hC02, 32'd10);
    rd_chk("instreth", 12'hB82, 32'd0);

    // read-only / unimplemented
    wr(12'hB00, 32'd100);
    wr(12'hC00, 32'h0000_1234);
    rd_chk("c00_ro", 12'hB00, 32'd101);
    wr(12'h344, 32'hFFFF_FFFF);
    rd_chk("mip_ro", 12'h344, 32'd0);
    rd_chk("mie_untouched", 12'h304, 32'd0);
    rd_chk("bad_rdata", 12'h7C0, 32'd0);
    check("bad_flag", {31'd0, bus.csr_addr_bad}, 32'd1);

    // WARL fields
    wr(12'h300, 32'h0000_0800);
    rd_chk("mpp01", 12'h300, 32'd0);
    wr(12'h300, 32'hFFFF_FFFF);
    rd_chk("mstatus_ones", 12'h300, 32'h0000_1888);
    wr(12'h305, 32'h1236_ABCE);
    rd_chk("mtvec_mode2", 12'h305, 32'h1236_ABCC);
    wr(12'h305, 32'h8000_0001);
    rd_chk("mtvec_vec", 12'h305, 32'h8000_0001);
    wr(12'h341, 32'h0000_1003);
    rd_chk("mepc_align", 12'h341, 32'h0000_1000);
    check("mepc_out", bus.mepc_out, 32'h0000_1000);

    // enter U with MIE=1 via mret
    wr(12'h300, 32'h0000_0080);
    do_mret();
    check("mret_mode_u", {30'd0, bus.current_mode}, 32'd0);
    rd_chk("mret_mstatus", 12'h300, 32'h0000_0088);

    // trap with colliding mscratch write
    bus.csr_we    = 1'b1;
    bus.csr_waddr = 12'h340;
    bus.csr_wdata = 32'h1111_1111;
    trap(32'd2, 32'h0000_1006, 32'h0000_0055);
    bus.csr_we    = 1'b0;
    rd_chk("trap_mepc", 12'h341, 32'h0000_1004);
    rd_chk("trap_mcause", 12'h342, 32'd2);
    rd_chk("trap_mtval", 12'h343, 32'h0000_0055);
    rd_chk("trap_mstatus", 12'h300, 32'h0000_0080);
    rd_chk("collide_mscr", 12'h340, 32'hDEAD_BEEF);
    check("trap_mode", {30'd0, bus.current_mode}, 32'd3);
    check("trap_mepc_out", bus.mepc_out, 32'h0000_1004);
    do_mret();
    check("mret2_mode", {30'd0, bus.current_mode}, 32'd0);
    rd_chk("mret2_mstatus", 12'h300, 32'h0000_0088);

    // interrupts and vectored target
    wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h0000_0888);
    wr(12'h304, 32'h0000_0080);
    bus.irq_ext = 1'b1;
    #1;
    check("irq_ext_masked", {31'd0, bus.irq_req}, 32'd0);
    bus.irq_ext   = 1'b0;
    bus.irq_timer = 1'b1;
    #1;
    check("irq_timer", {31'd0, bus.irq_req}, 32'd1);
    rd_chk("mip_mtip", 12'h344, 32'h0000_0080);
    bus.trap_cause = 32'h8000_0007;
    #1;
    check("tvec_vectored", bus.trap_vector, 32'h8000_001C);
    bus.trap_cause = 32'd2;
    #1;
    check("tvec_exc", bus.trap_vector, 32'h8000_0000);
    trap(32'h8000_0007, 32'h0000_2000, 32'd0);
    check("m_mie0_irq", {31'd0, bus.irq_req}, 32'd0);
    rd_chk("irq_trap_mst", 12'h300, 32'h0000_0080);
    rd_chk("irq_mcause", 12'h342, 32'h8000_0007);
    bus.irq_timer = 1'b0;

    // asynchronous reset mid-run
    #3 rst = 1'b1;
    #1;
    rd_chk("arst_cycle", 12'hB00, 32'd0);
    rd_chk("arst_instret", 12'hB02, 32'd0);
    rd_chk("arst_mscratch", 12'h340, 32'd0);
    rd_chk("arst_mtvec", 12'h305, 32'd0);
    check("arst_mode", {30'd0, bus.current_mode}, 32'd3);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
